// File: rtl/mul_seq_24.sv
// Sequential shift-add unsigned multiplier: one multiplier bit per clock,
// exact 2*WIDTH-bit product split into Result (low half) and ResultHi (high half).
module mul_seq_24 #(
    parameter int WIDTH = 24
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] ResultHi,
    output logic             Overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state;
    logic [2*WIDTH-1:0] mcand;     // multiplicand, shifted left once per RUN cycle
    logic [WIDTH-1:0]   mplier;    // multiplier, shifted right once per RUN cycle
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [CW-1:0]      count;

    // The last RUN edge loads the outputs from the sum formed on that same
    // edge, so the partial-product add is shared with the accumulator update.
    always_comb begin
        // NOTE: default assignment first so no path leaves acc_next unassigned (no latch).
        acc_next = acc;
        if (mplier[0]) begin
            acc_next = acc + mcand;
        end
    end

    always_ff @(posedge Clock) begin
        // NOTE: every register, including the datapath, is cleared by reset so an
        // aborted operation leaves nothing behind; state updates use <= only.
        if (Reset) begin
            state    <= IDLE;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            count    <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Result   <= '0;
            ResultHi <= '0;
            Overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        mcand  <= {{WIDTH{1'b0}}, A};
                        mplier <= B;
                        acc    <= '0;
                        count  <= CW'(WIDTH);
                        Busy   <= 1'b1;
                        state  <= RUN;
                    end
                end

                RUN: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count - 1'b1;
                    if (count == CW'(1)) begin
                        Result   <= acc_next[WIDTH-1:0];
                        ResultHi <= acc_next[2*WIDTH-1:WIDTH];
                        Overflow <= |acc_next[2*WIDTH-1:WIDTH];
                        Done     <= 1'b1;
                        state    <= DONE;
                    end
                end

                DONE: begin
                    Done  <= 1'b0;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    Done  <= 1'b0;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_24.sv
// Scoreboard bench for mul_seq_24: expected products queued at Start, compared on Done;
// directed latency, ignored-Start, hold, reset-abort and random operand checks.
module tb_mul_seq_24;

    localparam int W = 24;

    logic         Clock = 1'b0;
    logic         Reset;
    logic         Start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Result;
    logic [W-1:0] ResultHi;
    logic         Overflow;

    int checks    = 0;
    int failures  = 0;
    int done_count = 0;
    logic [2*W-1:0] exp_q[$];

    mul_seq_24 #(.WIDTH(W)) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Start   (Start),
        .A       (A),
        .B       (B),
        .Busy    (Busy),
        .Done    (Done),
        .Result  (Result),
        .ResultHi(ResultHi),
        .Overflow(Overflow)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2*W-1:0] ref_product(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] wa, wb;
        wa = {{W{1'b0}}, a};
        wb = {{W{1'b0}}, b};
        return wa * wb;
    endfunction

    // Scoreboard: compare each Done against the oldest queued product.
    always @(posedge Clock) begin
        logic [2*W-1:0] e;
        #2;
        if (Done) begin
            done_count++;
            check("done_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("product", 64'({ResultHi, Result}), 64'(e));
                check("overflow", 64'(Overflow), 64'(e[2*W-1:W] != '0));
            end
        end
    end

    // Drives one accepted operation (called one time unit after an edge, DUT idle),
    // then returns one time unit after the edge following the Done cycle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit directed,
                          input bit hold_chk, input logic [2*W-1:0] hold_val, input int dup_at);
        int lat, busy_cycles, hold_bad, dc0;
        dc0 = done_count;
        A = a;
        B = b;
        Start = 1'b1;
        exp_q.push_back(ref_product(a, b));
        @(posedge Clock); #1;
        Start = 1'b0;
        A = W'($urandom);
        B = W'($urandom);
        lat = 1;
        busy_cycles = 0;
        hold_bad = 0;
        forever begin
            if (Busy) busy_cycles++;
            if (Done || lat >= 100) break;
            if (hold_chk && {ResultHi, Result} !== hold_val) hold_bad++;
            if (lat == dup_at) begin
                Start = 1'b1;
                A = 24'd9;
                B = 24'd9;
            end else begin
                Start = 1'b0;
            end
            @(posedge Clock); #1;
            lat++;
        end
        Start = 1'b0;
        check("latency", 64'(lat), 64'd25);
        if (directed) check("busy_cycles", 64'(busy_cycles), 64'd25);
        if (hold_chk) check("hold", 64'(hold_bad), 64'd0);
        @(posedge Clock); #1;
        if (directed) begin
            check("done_pulse", 64'(Done), 64'd0);
            check("busy_idle", 64'(Busy), 64'd0);
            check("done_once", 64'(done_count - dc0), 64'd1);
        end
    endtask

    initial begin
        int dc0;
        logic [W-1:0] ra, rb;
        Reset = 1'b1;
        Start = 1'b0;
        A = '0;
        B = '0;
        repeat (2) @(posedge Clock);
        #1;
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_done", 64'(Done), 64'd0);
        check("rst_result", 64'({ResultHi, Result}), 64'd0);
        check("rst_ovf", 64'(Overflow), 64'd0);

        // Start on the first edge with reset released.
        Reset = 1'b0;
        run_op(24'd3, 24'd5, 1'b1, 1'b0, '0, -1);
        check("r3x5_lo", 64'(Result), 64'h00000F);
        check("r3x5_hi", 64'(ResultHi), 64'd0);

        run_op(24'hFFFFFF, 24'hFFFFFF, 1'b1, 1'b0, '0, -1);
        check("max_lo", 64'(Result), 64'h000001);
        check("max_hi", 64'(ResultHi), 64'hFFFFFE);
        check("max_ovf", 64'(Overflow), 64'd1);

        run_op(24'h001000, 24'h001000, 1'b1, 1'b0, '0, -1);
        check("pow_lo", 64'(Result), 64'd0);
        check("pow_hi", 64'(ResultHi), 64'd1);
        check("pow_ovf", 64'(Overflow), 64'd1);

        run_op(24'd0, 24'h123456, 1'b1, 1'b0, '0, -1);
        check("zero_res", 64'({ResultHi, Result}), 64'd0);
        check("zero_ovf", 64'(Overflow), 64'd0);

        // Second Start in RUN is ignored; idle gap leaves outputs unchanged.
        run_op(24'd7, 24'd6, 1'b1, 1'b0, '0, 10);
        check("ign_res", 64'(Result), 64'h00002A);
        repeat (3) @(posedge Clock);
        #1;
        check("idle_hold", 64'({ResultHi, Result}), 64'h2A);
        run_op(24'd1, 24'd1, 1'b1, 1'b1, 48'h2A, -1);
        check("next_res", 64'(Result), 64'd1);

        // Reset during RUN aborts the operation without a Done.
        A = 24'd100;
        B = 24'd200;
        Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        repeat (11) @(posedge Clock);
        #1;
        Reset = 1'b1;
        @(posedge Clock); #1;
        Reset = 1'b0;
        check("abort_busy", 64'(Busy), 64'd0);
        check("abort_done", 64'(Done), 64'd0);
        check("abort_res", 64'({ResultHi, Result}), 64'd0);
        check("abort_ovf", 64'(Overflow), 64'd0);
        dc0 = done_count;
        repeat (30) @(posedge Clock);
        #1;
        check("abort_no_done", 64'(done_count - dc0), 64'd0);
        run_op(24'd2, 24'd2, 1'b1, 1'b0, '0, -1);
        check("post_abort_res", 64'(Result), 64'd4);

        // Random operands, with occasional extreme values.
        dc0 = done_count;
        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            case ($urandom_range(0, 15))
                0: ra = '0;
                1: rb = '1;
                2: ra = '1;
                default: ;
            endcase
            run_op(ra, rb, 1'b0, 1'b0, '0, -1);
        end
        repeat (2) @(posedge Clock);
        #1;
        check("rand_done_count", 64'(done_count - dc0), 64'd1000);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
